keypad_scanner: RTL
===================

# keypad_scanner

Row-scanning front end for the 4x4 matrix keypad. Drives one active-low row at a time, samples the active-low column inputs through a two-flop synchronizer, and encodes a single pressed key into a 4-bit hex code. Sits directly upstream of `keypad_debouncer`: its `key_code`, `col` and `key_detected` outputs feed the debouncer. The debouncer's `scan_stop` output feeds back here to freeze scanning while a key is being debounced or held.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 3000: cycles each row is driven before its columns are sampled (1 ms at 3 MHz). Legal range is 2 or more.

Ports:
- `clk`  in  1  system clock, 3 MHz.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `col_in`  in  4  raw keypad column pins, active-low, pulled up externally, asynchronous to `clk`.
- `scan_stop`  in  1  from debouncer; 1 = hold the current row and the latched key.
- `row`  out  4  row drive, active-low, one-cold.
- `key_code`  out  4  hex code of the latched key.
- `col`  out  4  latched one-cold column pattern of the key; 4'b1111 when none.
- `key_detected`  out  1  1 while the latched key's column is low on the driven row.

## Operation
- Synchronizer: `col_in` passes through two flops to form `col_s`. The flops reset to 4'b1111. All decisions use `col_s` only.
- Row index `r` runs 0..3. `row` = ~(1<<r), so row 0 is 4'b1110 and row 3 is 4'b0111.
- Key map, listed row by row as col0..col3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
  - The codes are the hex values of those digits, for example row3/col1 = 4'h0.
- Valid press: exactly one bit of `col_s` is 0. Zero bits low, or two or more bits low (multi-key in a row), counts as no key.
- FSM states:
  - SCAN:
    - `settle_cnt` increments each cycle.
    - When `settle_cnt == SETTLE_CYCLES-1`, `col_s` is evaluated.
    - Valid press: latch `key_code`, set `col` = `col_s`, set `key_detected` to 1, go to LOCK. `r` is unchanged.
    - Otherwise: `r` advances to (r+1) mod 4, `settle_cnt` clears to 0, and the FSM stays in SCAN.
  - LOCK:
    - `row`, `key_code` and `col` are frozen.
    - Each cycle, `key_detected` <= (`col_s` bit of the latched column == 0).
    - Other keys on the same row, or on any row, are ignored.
    - Exit to SCAN only when `col_s` == 4'b1111 and `scan_stop` == 0. On exit, `r` advances to (r+1) mod 4, `settle_cnt` clears, `key_detected` is 0, and `col` returns to 4'b1111. `key_code` keeps its last value.
    - While `scan_stop` == 1, the FSM stays in LOCK regardless of the columns.
- `scan_stop` asserted while in SCAN: `settle_cnt` and `r` hold. Scanning resumes from the held count when `scan_stop` deasserts.

## Timing
- Reset values: `row` 4'b1110, `r` 0, `settle_cnt` 0, state SCAN, `key_code` 4'h0, `col` 4'b1111, `key_detected` 0, synchronizer 4'b1111.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Pin-to-decision latency: a `col_in` change is visible in `col_s` 2 cycles later.
- Row dwell in SCAN is exactly `SETTLE_CYCLES` cycles, so one full scan takes 4*`SETTLE_CYCLES` cycles.
- `key_detected`, `key_code` and `col` update on the clock edge where `settle_cnt == SETTLE_CYCLES-1` and a valid press is seen. They are visible the following cycle.
- In LOCK, a column release reaches `key_detected` 3 edges after the pin changes: 2 synchronizer edges plus 1 output register.
- Release and `scan_stop` deassert on the same cycle: exit to SCAN on that edge.
- Wrap-around: after row 3 dwell, the scanner moves to row 0 with no idle cycle.
- Reset mid-operation, in either state: all registers return immediately to their reset values.

## Test plan
Run the bench with `SETTLE_CYCLES` = 4.
- Reset, no key pressed: `row` cycles 1110, 1101, 1011, 0111, 1110 with each value held 4 cycles. `key_detected` stays 0 and `col` stays 4'b1111.
- Press row1/col1 (the model pulls `col_in`[1] low only while `row`[1] = 0), with `scan_stop` held 0:
  - At the row1 sample, `key_code` = 4'h5, `col` = 4'b1101 and `key_detected` = 1.
  - `row` then stays at 4'b1101.
- Raise `scan_stop`, press row1/col3 (B) as a second key, then release 5:
  - `key_code` stays 4'h5 throughout.
  - `key_detected` falls 3 cycles after the release of 5.
  - `row` stays frozen until `scan_stop` falls and all columns are high; the scanner then resumes on row2.
- Press row3/col0 and row3/col2 together: no detection on row3. Release col2: the next row3 sample gives `key_code` = 4'hE and `col` = 4'b1110.
- Press row3/col1: `key_code` = 4'h0 with `key_detected` = 1. This distinguishes the key "0" from the reset value of `key_code` by `key_detected`.
- Assert `rst_n` = 0 asynchronously mid-LOCK: all outputs go to their reset values without waiting for a clock edge. After release, scanning restarts at row0.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanning front end for a 4x4 active-low matrix keypad: drives one row at a
// time, synchronizes the columns, and latches a single pressed key as a hex code.
module keypad_scanner #(
   parameter int SETTLE_CYCLES = 3000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   input  logic       scan_stop,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic [3:0] col,
   output logic       key_detected
);

   localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_SCAN = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       col_meta_q;
   logic [3:0]       col_s_q;
   logic [1:0]       r_q, r_d;
   logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [3:0]       row_q, row_d;
   logic [3:0]       key_code_q, key_code_d;
   logic [3:0]       col_q, col_d;
   logic             key_det_q, key_det_d;
   logic [2:0]       col_dec_s;

   // Decode a one-cold column pattern into {valid, index}; anything else is no key
   function automatic logic [2:0] decode_col(input logic [3:0] c);
      logic [2:0] res;
      case (c)
         4'b1110: res = 3'b100;
         4'b1101: res = 3'b101;
         4'b1011: res = 3'b110;
         4'b0111: res = 3'b111;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b0000: code = 4'h1;
         4'b0001: code = 4'h2;
         4'b0010: code = 4'h3;
         4'b0011: code = 4'hA;
         4'b0100: code = 4'h4;
         4'b0101: code = 4'h5;
         4'b0110: code = 4'h6;
         4'b0111: code = 4'hB;
         4'b1000: code = 4'h7;
         4'b1001: code = 4'h8;
         4'b1010: code = 4'h9;
         4'b1011: code = 4'hC;
         4'b1100: code = 4'hE;
         4'b1101: code = 4'h0;
         4'b1110: code = 4'hF;
         4'b1111: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] row_drive(input logic [1:0] r);
      logic [3:0] drv;
      case (r)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1110;
      endcase
      return drv;
   endfunction

   assign col_dec_s = decode_col(col_s_q);

   // Two-flop synchronizer for the asynchronous column pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= 4'b1111;
         col_s_q    <= 4'b1111;
      end else begin
         col_meta_q <= col_in;
         col_s_q    <= col_meta_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_SCAN;
         r_q          <= 2'd0;
         settle_cnt_q <= '0;
         row_q        <= 4'b1110;
         key_code_q   <= 4'h0;
         col_q        <= 4'b1111;
         key_det_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         settle_cnt_q <= settle_cnt_d;
         row_q        <= row_d;
         key_code_q   <= key_code_d;
         col_q        <= col_d;
         key_det_q    <= key_det_d;
      end
   end

   // Next-state logic: scan rows, latch a single key, hold it until released
   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      settle_cnt_d = settle_cnt_q;
      key_code_d   = key_code_q;
      col_d        = col_q;
      key_det_d    = key_det_q;

      case (state_q)
         ST_SCAN: begin
            if (scan_stop) begin
               settle_cnt_d = settle_cnt_q;
               r_d          = r_q;
            end else if (settle_cnt_q == CNT_LAST) begin
               if (col_dec_s[2]) begin
                  key_code_d = key_map(r_q, col_dec_s[1:0]);
                  col_d      = col_s_q;
                  key_det_d  = 1'b1;
                  state_d    = ST_LOCK;
               end else begin
                  r_d          = r_q + 2'd1;
                  settle_cnt_d = '0;
               end
            end else begin
               settle_cnt_d = settle_cnt_q + CNT_W'(1);
            end
         end
         ST_LOCK: begin
            // Track only the latched column; other keys are ignored while locked
            key_det_d = ~|(~col_q & col_s_q);
            if ((col_s_q == 4'b1111) && !scan_stop) begin
               state_d      = ST_SCAN;
               r_d          = r_q + 2'd1;
               settle_cnt_d = '0;
               key_det_d    = 1'b0;
               col_d        = 4'b1111;
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: begin
            state_d      = ST_SCAN;
            r_d          = 2'd0;
            settle_cnt_d = '0;
            col_d        = 4'b1111;
            key_det_d    = 1'b0;
         end
      endcase

      row_d = row_drive(r_d);
   end

   assign row          = row_q;
   assign key_code     = key_code_q;
   assign col          = col_q;
   assign key_detected = key_det_q;

endmodule
